// File: rtl/chess_timer_core.sv
// chess_timer_core: two-player chess clock with synchronized buttons, per-second prescaler and timeout detection.
module chess_timer_core #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int MAX_COUNT = 999
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_p1_btn,
    input  logic       i_p2_btn,
    input  logic [9:0] i_preset,
    output logic [9:0] o_counter_1,
    output logic [9:0] o_counter_2,
    output logic [1:0] o_state_displays,
    output logic       o_tick
);
    localparam int PW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE = 2'b00, P1_RUN = 2'b01, P2_RUN = 2'b10, DONE = 2'b11} state_t;

    state_t          state, state_n;
    logic [2:0]      s1, s2, prev, rise;
    logic [PW-1:0]   presc, presc_n;
    logic [9:0]      c1_n, c2_n, ld;
    logic            running, tick, tick_n;

    // bit 0 start, bit 1 player 1, bit 2 player 2
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1          <= '0;
            s2          <= '0;
            prev        <= '0;
            state       <= IDLE;
            presc       <= '0;
            o_counter_1 <= '0;
            o_counter_2 <= '0;
            o_tick      <= 1'b0;
        end else begin
            s1          <= {i_p2_btn, i_p1_btn, i_start};
            s2          <= s1;
            prev        <= s2;
            state       <= state_n;
            presc       <= presc_n;
            o_counter_1 <= c1_n;
            o_counter_2 <= c2_n;
            o_tick      <= tick_n;
        end
    end

    always_comb begin
        rise    = s2 & ~prev;
        ld      = (i_preset > 10'(MAX_COUNT)) ? 10'(MAX_COUNT) : i_preset;
        running = (state == P1_RUN) || (state == P2_RUN);
        tick    = running && (presc == PW'(CLK_DIV - 1));
        state_n = state;
        c1_n    = o_counter_1;
        c2_n    = o_counter_2;
        tick_n  = 1'b0;
        case (state)
            IDLE: begin
                c1_n = ld;
                c2_n = ld;
                if (rise[0] && ld != 10'd0) state_n = P1_RUN;
            end
            P1_RUN: begin
                if (tick && o_counter_1 != 10'd0) begin
                    c1_n   = o_counter_1 - 10'd1;
                    tick_n = 1'b1;
                end
                // timeout takes priority over a simultaneous end-of-turn press
                if (tick && o_counter_1 <= 10'd1) state_n = DONE;
                else if (rise[1]) state_n = P2_RUN;
            end
            P2_RUN: begin
                if (tick && o_counter_2 != 10'd0) begin
                    c2_n   = o_counter_2 - 10'd1;
                    tick_n = 1'b1;
                end
                if (tick && o_counter_2 <= 10'd1) state_n = DONE;
                else if (rise[2]) state_n = P1_RUN;
            end
            DONE: if (rise[0]) state_n = IDLE;
        endcase
        presc_n = (!running || state_n != state || tick) ? '0 : presc + PW'(1);
    end

    assign o_state_displays = state;
endmodule

// File: doc/chess_timer_core.md
CHESS_TIMER_CORE -- requirements
Module: chess_timer_core

Interface
REQ-001 Parameter CLK_DIV, default 50_000_000, clock cycles per one-second count tick (≥2).
REQ-002 Parameter MAX_COUNT, default 999, ceiling for any loaded count value (3-digit display limit).
REQ-003 i_clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_start  input  1  start/restart button, active-high level, asynchronous to i_clk.
REQ-006 i_p1_btn  input  1  player-1 end-of-turn button, active-high level, asynchronous.
REQ-007 i_p2_btn  input  1  player-2 end-of-turn button, active-high level, asynchronous.
REQ-008 i_preset  input  10  starting seconds per player, unsigned.
REQ-009 o_counter_1  output  10  player-1 remaining seconds, binary, 0..MAX_COUNT.
REQ-010 o_counter_2  output  10  player-2 remaining seconds, binary, 0..MAX_COUNT.
REQ-011 o_state_displays  output  2  FSM state code: 00 IDLE, 01 P1_RUN, 10 P2_RUN, 11 DONE.
REQ-012 o_tick  output  1  one-cycle pulse each time a running counter decrements.

Function
REQ-013 Each button input SHALL pass through a 2-flop synchronizer plus a previous-value register; only rising edges act.
REQ-014 A button rising at the input SHALL change state on the 3rd rising i_clk edge after it is sampled high; held buttons SHALL act once.
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 only in P1_RUN/P2_RUN, producing a tick on the cycle it wraps; cleared to 0 on every state change and in IDLE/DONE.
REQ-016 IDLE: both counters SHALL load min(i_preset, MAX_COUNT) every cycle; start edge with loaded value ≠0 -> P1_RUN; start edge with value 0 SHALL be ignored.
REQ-017 P1_RUN: on tick o_counter_1 SHALL decrement by 1 and o_tick SHALL pulse; o_counter_2 SHALL hold.
REQ-018 P1_RUN: p1 edge -> P2_RUN; p2 edge and start edge SHALL be ignored.
REQ-019 P2_RUN: symmetric to REQ-017/018 with roles swapped (p2 edge -> P1_RUN).
REQ-020 Timeout: tick while the running counter equals 1 SHALL set it to 0 and enter DONE on the same edge.
REQ-021 Simultaneous timeout tick and end-of-turn edge: timeout SHALL win (DONE, counter 0).
REQ-022 Counters SHALL never wrap below 0 nor exceed MAX_COUNT.
REQ-023 DONE: counters SHALL hold (loser's counter = 0, identifying the winner downstream); p1/p2 edges ignored; start edge -> IDLE.
REQ-024 o_state_displays SHALL be the registered state, o_counter_1/2 registered values; no combinational input-to-output path.

Reset
REQ-025 While i_rst high: state IDLE (00), o_counter_1 = o_counter_2 = 0, prescaler 0, o_tick 0, all synchronizer/edge registers 0.
REQ-026 First rising edge after i_rst falls SHALL load both counters with min(i_preset, MAX_COUNT).
REQ-027 Reset asserted mid-operation (any state, mid-prescale) SHALL immediately force REQ-025 values without waiting for a clock edge.

Verification (CLK_DIV=4)
REQ-028 i_preset=5, start pulse -> 01 three edges later; counter_1 5->4->3 every 4 cycles, o_tick pulses each decrement, counter_2 stays 5.
REQ-029 In P1_RUN press p1 -> 10, prescaler restarts, counter_2 decrements 4 cycles later, counter_1 frozen; press p2 -> back to 01.
REQ-030 Let counter_1 run 1->0 -> state 11, counter_1=0, counter_2 unchanged; p1/p2 presses no effect; start -> 00 with counters reloaded.
REQ-031 i_preset=1023 in IDLE -> both counters read 999; i_preset=0 plus start -> state stays 00.
REQ-032 Timeout tick coincident with p1 edge at counter_1=1 -> state 11, counter_1=0.
REQ-033 Assert i_rst between clock edges during P2_RUN -> outputs 0/00 immediately; release -> counters = preset next edge.
